// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register: valid/ready handshake, 2-entry skid buffer, flush bubble insertion.
// Optional stall/flush performance counters enabled by defining ID_EX_PERF_EN.
module id_ex_elastic_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PCW  = 30,
  parameter int unsigned REGW = 5,
  parameter int unsigned WBW  = 2,
  parameter int unsigned MW   = 3,
  parameter int unsigned EXW  = 3,
`ifdef ID_EX_PERF_EN
  parameter int unsigned CNTW = 16,
`endif
  localparam int unsigned DW  = PCW + 3*XLEN + 2*REGW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [WBW-1:0] in_wb,
  input  logic [MW-1:0]  in_m,
  input  logic [EXW-1:0] in_ex,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [WBW-1:0] out_wb,
  output logic [MW-1:0]  out_m,
  output logic           out_reg_dst,
  output logic           out_alu_src,
  output logic [EXW-3:0] out_alu_op
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
`endif
);

  logic           main_valid_q, main_valid_d;
  logic [DW-1:0]  main_data_q,  main_data_d;
  logic [WBW-1:0] main_wb_q,    main_wb_d;
  logic [MW-1:0]  main_m_q,     main_m_d;
  logic [EXW-1:0] main_ex_q,    main_ex_d;

  logic           skid_valid_q, skid_valid_d;
  logic [DW-1:0]  skid_data_q,  skid_data_d;
  logic [WBW-1:0] skid_wb_q,    skid_wb_d;
  logic [MW-1:0]  skid_m_q,     skid_m_d;
  logic [EXW-1:0] skid_ex_q,    skid_ex_d;

  logic accept;
  logic pop;

  assign accept = in_valid & ~skid_valid_q;
  assign pop    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_wb_d    = main_wb_q;
    main_m_d     = main_m_q;
    main_ex_d    = main_ex_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_wb_d    = skid_wb_q;
    skid_m_d     = skid_m_q;
    skid_ex_d    = skid_ex_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_wb_d    = '0;
      main_m_d     = '0;
      main_ex_d    = '0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_wb_d    = skid_wb_q;
        main_m_d     = skid_m_q;
        main_ex_d    = skid_ex_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_wb_d    = in_wb;
        main_m_d     = in_m;
        main_ex_d    = in_ex;
      end else begin
        // Bubble: control zeroed in the flops, payload left as-is
        main_valid_d = 1'b0;
        main_wb_d    = '0;
        main_m_d     = '0;
        main_ex_d    = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_wb_d    = in_wb;
      skid_m_d     = in_m;
      skid_ex_d    = in_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_wb_q    <= '0;
      main_m_q     <= '0;
      main_ex_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_wb_q    <= '0;
      skid_m_q     <= '0;
      skid_ex_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_wb_q    <= main_wb_d;
      main_m_q     <= main_m_d;
      main_ex_q    <= main_ex_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_wb_q    <= skid_wb_d;
      skid_m_q     <= skid_m_d;
      skid_ex_q    <= skid_ex_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_data    = main_data_q;
  assign out_wb      = main_wb_q;
  assign out_m       = main_m_q;
  assign out_reg_dst = main_ex_q[0];
  assign out_alu_src = main_ex_q[1];
  assign out_alu_op  = main_ex_q[EXW-1:2];

`ifdef ID_EX_PERF_EN
  logic [CNTW-1:0] stall_cnt_q;
  logic [CNTW-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: queue-based FIFO model checked every cycle plus directed literal checks.
module tb_id_ex_elastic_reg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PCW  = 30;
  localparam int unsigned REGW = 5;
  localparam int unsigned WBW  = 2;
  localparam int unsigned MW   = 3;
  localparam int unsigned EXW  = 3;
  localparam int unsigned DW   = PCW + 3*XLEN + 2*REGW;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [WBW-1:0] wb;
    logic [MW-1:0]  m;
    logic [EXW-1:0] ex;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, out_ready;
  logic [DW-1:0]  in_data;
  logic [WBW-1:0] in_wb;
  logic [MW-1:0]  in_m;
  logic [EXW-1:0] in_ex;
  logic           in_ready, out_valid, out_reg_dst, out_alu_src;
  logic [DW-1:0]  out_data;
  logic [WBW-1:0] out_wb;
  logic [MW-1:0]  out_m;
  logic [EXW-3:0] out_alu_op;

  always #5 clk = ~clk;

`ifdef ID_EX_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic           s_in_ready, s_out_valid, s_reg_dst, s_alu_src;
  logic [DW-1:0]  s_out_data;
  logic [WBW-1:0] s_out_wb;
  logic [MW-1:0]  s_out_m;
  logic [EXW-3:0] s_alu_op;

  id_ex_elastic_reg #(.XLEN(XLEN), .PCW(PCW), .REGW(REGW), .WBW(WBW), .MW(MW), .EXW(EXW), .CNTW(2)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_wb(s_out_wb), .out_m(s_out_m), .out_reg_dst(s_reg_dst), .out_alu_src(s_alu_src),
    .out_alu_op(s_alu_op), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));
`endif

  id_ex_elastic_reg #(
    .XLEN(XLEN), .PCW(PCW), .REGW(REGW), .WBW(WBW), .MW(MW), .EXW(EXW)
`ifdef ID_EX_PERF_EN
    , .CNTW(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wb(out_wb), .out_m(out_m), .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src),
    .out_alu_op(out_alu_op)
`ifdef ID_EX_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [PCW-1:0] pc4, input logic [7:0] tag);
    return {pc4, {24'h0, tag}, {24'hA5A5A5, tag}, {24'h0, ~tag}, tag[4:0], tag[4:0] ^ 5'h1f};
  endfunction

  // Model: the register pair behaves as a 2-deep FIFO whose head is presented to EX.
  ent_t        mq[$];
  logic [DW-1:0] m_last = '0;
  int          sz;
`ifdef ID_EX_PERF_EN
  int          m_stall = 0;
  int          m_flush = 0;
`endif

  always @(posedge clk) begin
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_last = '0;
`ifdef ID_EX_PERF_EN
      m_stall = 0;
      m_flush = 0;
`endif
    end else begin
`ifdef ID_EX_PERF_EN
      if (sz > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush && sz > 0 && m_flush < 65535) m_flush++;
`endif
      if (flush) mq.delete();
      else begin
        if (sz > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && sz < 2) mq.push_back(ent_t'{d: in_data, wb: in_wb, m: in_m, ex: in_ex});
      end
      if (mq.size() > 0) m_last = mq[0].d;
    end
  end

  ent_t cur;
  logic exp_valid;
  always @(negedge clk) begin
    if (armed) begin
      exp_valid = (mq.size() > 0);
      cur = exp_valid ? mq[0] : '0;
      chk("m_out_valid", DW'(out_valid), DW'(exp_valid));
      chk("m_in_ready", DW'(in_ready), DW'(mq.size() < 2));
      chk("m_out_data", out_data, m_last);
      chk("m_out_wb", DW'(out_wb), DW'(cur.wb));
      chk("m_out_m", DW'(out_m), DW'(cur.m));
      chk("m_reg_dst", DW'(out_reg_dst), DW'(cur.ex[0]));
      chk("m_alu_src", DW'(out_alu_src), DW'(cur.ex[1]));
      chk("m_alu_op", DW'(out_alu_op), DW'(cur.ex[2]));
`ifdef ID_EX_PERF_EN
      chk("m_stall_cnt", DW'(stall_cnt), DW'(m_stall));
      chk("m_flush_cnt", DW'(flush_cnt), DW'(m_flush));
`endif
    end
  end

  task automatic step(input logic r, input logic fl, input logic v, input logic [DW-1:0] d,
                      input logic [1:0] wb, input logic [2:0] m, input logic [2:0] ex, input logic ordy);
    rst = r; flush = fl; in_valid = v; in_data = d; in_wb = wb; in_m = m; in_ex = ex; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, 3'b000, 3'b000, ordy);
  endtask

  logic [DW-1:0] A, B, C, D, E, F, G, H;

  initial begin
    A = mk(30'h100, 8'h0A); B = mk(30'h104, 8'h0B); C = mk(30'h108, 8'h0C);
    D = mk(30'h200, 8'h0D); E = mk(30'h204, 8'h0E); F = mk(30'h208, 8'h0F);
    G = mk(30'h300, 8'h10); H = mk(30'h304, 8'h11);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_wb = '0; in_m = '0; in_ex = '0; out_ready = 1'b0;
    @(posedge clk); #2;
    armed = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, 2'b00, 3'b000, 3'b000, 1'b0);
    // reset state
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_wb", DW'(out_wb), DW'(0));
    chk("rst_out_m", DW'(out_m), DW'(0));
    chk("rst_alu_op", DW'(out_alu_op), DW'(0));
    chk("rst_out_data", out_data, DW'(0));

    // back-to-back with EX always ready
    step(1'b0, 1'b0, 1'b1, A, 2'b11, 3'b010, 3'b101, 1'b1);
    chk("b2b_A_valid", DW'(out_valid), DW'(1));
    chk("b2b_A_pc4", DW'(out_data[DW-1 -: PCW]), DW'(30'h100));
    chk("b2b_A_wb", DW'(out_wb), DW'(3));
    chk("b2b_A_regdst", DW'(out_reg_dst), DW'(1));
    chk("b2b_A_alusrc", DW'(out_alu_src), DW'(0));
    chk("b2b_A_aluop", DW'(out_alu_op), DW'(1));
    step(1'b0, 1'b0, 1'b1, B, 2'b01, 3'b100, 3'b010, 1'b1);
    chk("b2b_B_data", out_data, B);
    chk("b2b_B_alusrc", DW'(out_alu_src), DW'(1));
    step(1'b0, 1'b0, 1'b1, C, 2'b10, 3'b001, 3'b110, 1'b1);
    chk("b2b_C_data", out_data, C);
    idle(1'b1);
    chk("b2b_drained", DW'(out_valid), DW'(0));
    chk("b2b_hold_data", out_data, C);

    // back-pressure fills skid, third entry held off
    step(1'b0, 1'b0, 1'b1, A, 2'b11, 3'b010, 3'b101, 1'b0);
    step(1'b0, 1'b0, 1'b1, B, 2'b01, 3'b100, 3'b010, 1'b0);
    chk("bp_in_ready_low", DW'(in_ready), DW'(0));
    chk("bp_head_A", out_data, A);
    step(1'b0, 1'b0, 1'b1, C, 2'b10, 3'b001, 3'b110, 1'b0);
    chk("bp_still_A", out_data, A);
    step(1'b0, 1'b0, 1'b1, C, 2'b10, 3'b001, 3'b110, 1'b1);
    chk("bp_head_B", out_data, B);
    chk("bp_in_ready_high", DW'(in_ready), DW'(1));
    step(1'b0, 1'b0, 1'b1, C, 2'b10, 3'b001, 3'b110, 1'b1);
    chk("bp_head_C", out_data, C);
    idle(1'b1);

    // flush with both slots full and a new entry offered
    step(1'b0, 1'b0, 1'b1, D, 2'b11, 3'b111, 3'b111, 1'b0);
    step(1'b0, 1'b0, 1'b1, E, 2'b11, 3'b111, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b1, F, 2'b11, 3'b111, 3'b111, 1'b0);
    chk("fl_out_valid", DW'(out_valid), DW'(0));
    chk("fl_out_wb", DW'(out_wb), DW'(0));
    chk("fl_out_m", DW'(out_m), DW'(0));
    chk("fl_in_ready", DW'(in_ready), DW'(1));
    idle(1'b1);
    idle(1'b1);
    chk("fl_nothing_leaks", DW'(out_valid), DW'(0));

    // reset with skid full and EX stalled
    step(1'b0, 1'b0, 1'b1, G, 2'b11, 3'b101, 3'b011, 1'b0);
    step(1'b0, 1'b0, 1'b1, H, 2'b10, 3'b110, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b1, A, 2'b11, 3'b111, 3'b111, 1'b0);
    chk("rst2_out_valid", DW'(out_valid), DW'(0));
    chk("rst2_in_ready", DW'(in_ready), DW'(1));
    chk("rst2_out_data", out_data, DW'(0));
    chk("rst2_alu_src", DW'(out_alu_src), DW'(0));
    idle(1'b1);

    // mixed traffic pattern, model checks every cycle
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (i == 25), ((i % 3) != 2), mk(30'(12'h400 + 4*i), 8'(i)),
           2'(i), 3'(i + 1), 3'(i * 3), ((i % 4) != 1));
    end
    idle(1'b1);
    idle(1'b1);

`ifdef ID_EX_PERF_EN
    step(1'b1, 1'b0, 1'b0, '0, 2'b00, 3'b000, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b1, A, 2'b11, 3'b010, 3'b101, 1'b0);
    for (int k = 0; k < 5; k++) idle(1'b0);
    chk("perf_stall5", DW'(stall_cnt), DW'(5));
    chk("perf_small_stall_sat", DW'(s_stall_cnt), DW'(3));
    idle(1'b0);
    chk("perf_stall6", DW'(stall_cnt), DW'(6));
    chk("perf_small_stall6", DW'(s_stall_cnt), DW'(3));
    step(1'b0, 1'b1, 1'b0, '0, 2'b00, 3'b000, 3'b000, 1'b1);
    step(1'b0, 1'b0, 1'b1, B, 2'b01, 3'b100, 3'b010, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 2'b00, 3'b000, 3'b000, 1'b1);
    chk("perf_flush2", DW'(flush_cnt), DW'(2));
    chk("perf_small_flush2", DW'(s_flush_cnt), DW'(2));
    step(1'b0, 1'b1, 1'b0, '0, 2'b00, 3'b000, 3'b000, 1'b1);
    chk("perf_flush_empty", DW'(flush_cnt), DW'(2));
`endif

    idle(1'b1);
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
